// File: rtl/vga_pkg.sv
// vga_pkg: RGB565 colours, 640x480 timing constants and the
// pattern-mode encoding shared by the VGA pixel path.
package vga_pkg;

  localparam logic [15:0] C_RED     = 16'hF800;
  localparam logic [15:0] C_WHITE   = 16'hFFFF;
  localparam logic [15:0] C_BLACK   = 16'h0000;
  localparam logic [15:0] C_BLUE    = 16'h001F;
  localparam logic [15:0] C_YELLOW  = 16'hFFE0;
  localparam logic [15:0] C_CYAN    = 16'h07FF;
  localparam logic [15:0] C_GREEN   = 16'h07E0;
  localparam logic [15:0] C_MAGENTA = 16'hF81F;

  localparam int H_ACT  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = 800;
  localparam int V_ACT  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = 525;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRID  = 2'd3
  } mode_e;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       oor;
    logic       border;
    logic       chk;
    logic       grid;
    logic [2:0] bar;
    mode_e      mode;
  } s1_t;

  function automatic logic [15:0] bar_colour(
    input logic [2:0] idx
  );
    logic [15:0] c;
    c = C_BLACK;
    unique case (idx)
      3'd0: c = C_WHITE;
      3'd1: c = C_YELLOW;
      3'd2: c = C_CYAN;
      3'd3: c = C_GREEN;
      3'd4: c = C_MAGENTA;
      3'd5: c = C_RED;
      3'd6: c = C_BLUE;
      3'd7: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_key_debounce.sv
// vga_key_debounce: 2-flop synchronizer plus stable-level counter,
// emitting a one-cycle pulse on each debounced press (1->0).
module vga_key_debounce #(
  parameter int CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW =
    (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0  <= 1'b1;
      sync1  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync0 <= key_n;
      sync1 <= sync0;
      press <= 1'b0;
      if (sync1 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync1;
        cnt    <= '0;
        press  <= ~sync1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: two-stage RGB565 test-pattern source with
// frame-aligned mode switching. Optional border: VGA_PATTERN_BORDER_EN.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        de_in,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  input  logic        key_n,
  output logic        hys,
  output logic        vys,
  output logic        de_out,
  output logic [15:0] lcd_rgb,
  output logic [1:0]  mode
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic        press;
  logic [1:0]  pending_mode;
  logic        vs_fall;
  logic [31:0] xw;
  logic [31:0] yw;
  logic [2:0]  bar_c;
  logic [15:0] pat;
  logic [15:0] colour;
  s1_t         s1_c;
  s1_t         s1;

  vga_key_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk  (clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .press(press)
  );

  assign xw      = {22'd0, x_in};
  assign yw      = {22'd0, y_in};
  assign vs_fall = s1.vs & ~vs_in;

  // Bar index by threshold compare; no divider.
  always_comb begin
    bar_c = '0;
    for (int k = 1; k < 8; k++) begin
      if (xw >= k * BAR_W) bar_c = 3'(k);
    end
  end

  always_comb begin
    s1_c      = '0;
    s1_c.hs   = hs_in;
    s1_c.vs   = vs_in;
    s1_c.de   = de_in;
    s1_c.oor  = (xw >= H_ACTIVE) || (yw >= V_ACTIVE);
    s1_c.chk  = x_in[5] ^ y_in[5];
    s1_c.grid = (x_in[5:0] == 6'd0) ||
                (y_in[5:0] == 6'd0);
    s1_c.bar  = bar_c;
    s1_c.mode = mode_e'(mode);
`ifdef VGA_PATTERN_BORDER_EN
    s1_c.border = (xw == 0) || (xw == H_ACTIVE - 1) ||
                  (yw == 0) || (yw == V_ACTIVE - 1);
`else
    s1_c.border = 1'b0;
`endif
  end

  // A press coinciding with a boundary lands on the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1           <= '0;
      s1.hs        <= 1'b1;
      s1.vs        <= 1'b1;
      pending_mode <= 2'd0;
      mode         <= 2'd0;
    end else begin
      s1 <= s1_c;
      if (press) pending_mode <= pending_mode + 2'd1;
      if (vs_fall) mode <= pending_mode;
    end
  end

  always_comb begin
    pat = C_BLACK;
    unique case (s1.mode)
      MODE_SOLID: pat = C_RED;
      MODE_BARS:  pat = bar_colour(s1.bar);
      MODE_CHECK: pat = s1.chk ? C_WHITE : C_BLACK;
      MODE_GRID:  pat = s1.grid ? C_WHITE : C_BLUE;
    endcase
  end

  always_comb begin
    colour = C_BLACK;
    unique case (1'b1)
      (!s1.de || s1.oor):
        colour = C_BLACK;
      (s1.de && !s1.oor && s1.border):
        colour = C_WHITE;
      (s1.de && !s1.oor && !s1.border):
        colour = pat;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hys     <= 1'b1;
      vys     <= 1'b1;
      de_out  <= 1'b0;
      lcd_rgb <= C_BLACK;
    end else begin
      hys     <= s1.hs;
      vys     <= s1.vs;
      de_out  <= s1.de;
      lcd_rgb <= colour;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: directed timing/key stimulus, per-cycle
// reference-model compare plus literal pixel and mode checks.
module tb_vga_pattern_gen;

  localparam int DB = 16;
  localparam logic [18:0] RST_OUT = {1'b1, 1'b1, 1'b0, 16'h0};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic        de_in = 1'b0;
  logic [9:0]  x_in  = '0;
  logic [9:0]  y_in  = '0;
  logic        key_n = 1'b1;
  logic        hys;
  logic        vys;
  logic        de_out;
  logic [15:0] lcd_rgb;
  logic [1:0]  mode;

  int checks   = 0;
  int failures = 0;

  int          m_mode    = 0;
  int          m_pend    = 0;
  bit          m_vs_prev = 1'b1;
  logic [18:0] m_prev    = RST_OUT;
  logic [18:0] m_exp;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_ACTIVE       (640),
    .V_ACTIVE       (480),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .hs_in  (hs_in),
    .vs_in  (vs_in),
    .de_in  (de_in),
    .x_in   (x_in),
    .y_in   (y_in),
    .key_n  (key_n),
    .hys    (hys),
    .vys    (vys),
    .de_out (de_out),
    .lcd_rgb(lcd_rgb),
    .mode   (mode)
  );

  function automatic logic [15:0] px(
    bit de, int x, int y, int m
  );
    if (!de || x >= 640 || y >= 480) return 16'h0000;
`ifdef VGA_PATTERN_BORDER_EN
    if (x == 0 || x == 639 || y == 0 || y == 479)
      return 16'hFFFF;
`endif
    case (m)
      0: return 16'hF800;
      1: begin
        case (x / 80)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2: return (((x / 32) % 2) != ((y / 32) % 2))
                ? 16'hFFFF : 16'h0000;
      default: return ((x % 64 == 0) || (y % 64 == 0))
                ? 16'hFFFF : 16'h001F;
    endcase
  endfunction

  // Reference: output = previous sample's pixel; mode loads on vs fall.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_exp     = RST_OUT;
      m_prev    = RST_OUT;
      m_mode    = 0;
      m_pend    = 0;
      m_vs_prev = 1'b1;
    end else begin
      m_exp  = m_prev;
      m_prev = {hs_in, vs_in, de_in,
                px(de_in, int'(x_in), int'(y_in), m_mode)};
      if (m_vs_prev && !vs_in) m_mode = m_pend;
      m_vs_prev = vs_in;
    end
    #1;
    checks++;
    if ({hys, vys, de_out, lcd_rgb} !== m_exp ||
        mode !== 2'(m_mode)) begin
      failures++;
      $display("FAIL pipe t=%0t got hs=%b vs=%b de=%b rgb=%h mode=%0d want hs=%b vs=%b de=%b rgb=%h mode=%0d",
               $time, hys, vys, de_out, lcd_rgb, mode,
               m_exp[18], m_exp[17], m_exp[16], m_exp[15:0],
               m_mode);
    end
  end

  task automatic chk(string name, logic [15:0] got,
                     logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic cyc(bit h, bit v, bit d, int x, int y);
    @(negedge clk);
    hs_in = h;
    vs_in = v;
    de_in = d;
    x_in  = 10'(x);
    y_in  = 10'(y);
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1, 1, 0, 0, 0);
  endtask

  task automatic line(int y);
    int sp [12] = '{31, 32, 63, 64, 65, 79, 80, 159,
                    160, 639, 640, 700};
    repeat (3) cyc(0, 1, 0, 0, 0);
    repeat (2) cyc(1, 1, 0, 0, 0);
    for (int x = 0; x < 640; x += 9) cyc(1, 1, 1, x, y);
    foreach (sp[i]) cyc(1, 1, 1, sp[i], y);
    idle(2);
  endtask

  task automatic frame_start();
    idle(2);
    repeat (3) cyc(0, 0, 0, 0, 0);
    idle(3);
  endtask

  task automatic frame();
    int ys [10] = '{0, 10, 31, 32, 33, 64, 100, 200,
                    479, 480};
    frame_start();
    foreach (ys[i]) line(ys[i]);
  endtask

  task automatic press();
    key_n = 1'b0;
    idle(DB + 10);
    key_n = 1'b1;
    idle(DB + 10);
    m_pend = (m_pend + 1) % 4;
  endtask

  task automatic pix_check(int x, int y, logic [15:0] want,
                           string name);
    cyc(1, 1, 1, x, y);
    cyc(1, 1, 0, 0, 0);
    @(posedge clk);
    #2;
    chk(name, lcd_rgb, want);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_hys", {15'd0, hys}, 16'd1);
    chk("rst_vys", {15'd0, vys}, 16'd1);
    chk("rst_de", {15'd0, de_out}, 16'd0);
    chk("rst_rgb", lcd_rgb, 16'h0000);
    chk("rst_mode", {14'd0, mode}, 16'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    frame();
    pix_check(100, 100, 16'hF800, "m0_solid");

    line(100);
    press();
    line(200);
    chk("mode_hold", {14'd0, mode}, 16'd0);
    frame_start();
    chk("mode_to1", {14'd0, mode}, 16'd1);
    pix_check(0, 100, 16'hFFFF, "bar_x0");
    pix_check(80, 100, 16'hFFE0, "bar_x80");
`ifdef VGA_PATTERN_BORDER_EN
    pix_check(639, 100, 16'hFFFF, "bar_x639");
`else
    pix_check(639, 100, 16'h0000, "bar_x639");
`endif
    pix_check(400, 100, 16'hF800, "bar_x400");
    frame();

    repeat (4) begin
      key_n = 1'b0;
      idle(DB - 2);
      key_n = 1'b1;
      idle(DB);
    end
    frame();
    chk("glitch_mode", {14'd0, mode}, 16'd1);

    press();
    press();
    press();
    chk("accum_hold", {14'd0, mode}, 16'd1);
    frame();
    chk("wrap_mode", {14'd0, mode}, 16'd0);

    press();
    press();
    frame();
    chk("mode_to2", {14'd0, mode}, 16'd2);
    pix_check(32, 0, 16'hFFFF, "chk_32_0");
    pix_check(32, 32, 16'h0000, "chk_32_32");

    press();
    frame();
    chk("mode_to3", {14'd0, mode}, 16'd3);
    pix_check(64, 10, 16'hFFFF, "grid_64_10");
    pix_check(65, 10, 16'h001F, "grid_65_10");
    pix_check(700, 10, 16'h0000, "oor_700");
`ifdef VGA_PATTERN_BORDER_EN
    pix_check(639, 200, 16'hFFFF, "edge_639");
`else
    pix_check(639, 200, 16'h001F, "edge_639");
`endif

    press();
    cyc(1, 1, 1, 50, 100);
    cyc(1, 1, 1, 60, 100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_hys", {15'd0, hys}, 16'd1);
    chk("mid_vys", {15'd0, vys}, 16'd1);
    chk("mid_de", {15'd0, de_out}, 16'd0);
    chk("mid_rgb", lcd_rgb, 16'h0000);
    chk("mid_mode", {14'd0, mode}, 16'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hs_in = 1'b1;
    vs_in = 1'b1;
    de_in = 1'b1;
    x_in  = 10'd100;
    y_in  = 10'd100;
    cyc(1, 1, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("post_rst_px", lcd_rgb, 16'hF800);
    chk("post_rst_mode", {14'd0, mode}, 16'd0);
`ifdef VGA_PATTERN_BORDER_EN
    pix_check(0, 200, 16'hFFFF, "border_0_200");
`else
    pix_check(0, 200, 16'hF800, "border_0_200");
`endif
    frame();
    chk("end_mode", {14'd0, mode}, 16'd0);

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
